// File: rtl/phase_timer.sv
// Prescaled down-counting phase timer with one-shot / auto-reload modes and a one-cycle roll pulse.
// Optional hold input is enabled by defining TIMER_HOLD_EN.
module phase_timer #(
    parameter int WIDTH      = 7,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
`ifdef TIMER_HOLD_EN
    input  logic                  hold,
`endif
    input  logic [WIDTH-1:0]      duration,
    input  logic [PRESCALE_W-1:0] presc,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tick,
    output logic                  roll
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ZERO  = '0;
    localparam logic [WIDTH-1:0]      CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_ZERO  = '0;
    localparam logic [PRESCALE_W-1:0] PRE_ONE   = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [WIDTH-1:0]        dur_q, dur_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
    logic                    periodic_q, periodic_d;
    logic                    roll_q, roll_d;
    logic                    hold_w;

`ifdef TIMER_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // A held timer neither ticks nor expires.
    assign tick  = (state_q == RUN) && !hold_w && (pcnt_q == presc_q);
    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign roll  = roll_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dur_d      = dur_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        periodic_d = periodic_q;
        roll_d     = 1'b0;

        if (stop) begin
            // Stop outranks start even in IDLE, where it simply swallows the start.
            if (state_q == RUN) begin
                state_d = IDLE;
                pcnt_d  = PRE_ZERO;
            end
        end else if (start) begin
            dur_d      = duration;
            presc_d    = presc;
            periodic_d = periodic;
            pcnt_d     = PRE_ZERO;
            if (duration == CNT_ZERO) begin
                state_d = IDLE;
                count_d = CNT_ZERO;
                roll_d  = 1'b1;
            end else begin
                state_d = RUN;
                count_d = duration;
            end
        end else if (state_q == RUN && !hold_w) begin
            if (tick) begin
                pcnt_d = PRE_ZERO;
                if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    roll_d = 1'b1;
                    if (periodic_q) begin
                        count_d = dur_q;
                    end else begin
                        count_d = CNT_ZERO;
                        state_d = IDLE;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= CNT_ZERO;
            dur_q      <= CNT_ZERO;
            presc_q    <= PRE_ZERO;
            pcnt_q     <= PRE_ZERO;
            periodic_q <= 1'b0;
            roll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dur_q      <= dur_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            periodic_q <= periodic_d;
            roll_q     <= roll_d;
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Directed scoreboard bench for phase_timer; covers the hold path when TIMER_HOLD_EN is defined.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, periodic, hold;
    logic [6:0] duration;
    logic [7:0] presc;
    logic [6:0] count;
    logic       busy, tick, roll;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        int    cnt;
        int    busy;
        int    roll;
        int    tick;
    } exp_t;

    exp_t sb[$];

    phase_timer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
`ifdef TIMER_HOLD_EN
        .hold     (hold),
`endif
        .duration (duration),
        .presc    (presc),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .roll     (roll)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Push the expectation for the next edge, clock it, then pop and compare (tick < 0 = don't care).
    task automatic cyc(input string tag, input int c, input int b, input int r, input int t);
        exp_t e;
        e.tag = tag; e.cnt = c; e.busy = b; e.roll = r; e.tick = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp({e.tag, "_count"}, int'(count), e.cnt);
        cmp({e.tag, "_busy"},  int'(busy),  e.busy);
        cmp({e.tag, "_roll"},  int'(roll),  e.roll);
        if (e.tick >= 0) cmp({e.tag, "_tick"}, int'(tick), e.tick);
    endtask

    task automatic go(input int d, input int p, input bit per);
        duration = 7'(d); presc = 8'(p); periodic = per; start = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 0; stop = 0; periodic = 0; hold = 0;
        duration = '0; presc = '0;
        #1;
        cmp("rst0_count", int'(count), 0);
        cmp("rst0_busy", int'(busy), 0);
        cmp("rst0_tick", int'(tick), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc("idle", 0, 0, 0, 0);

        // One-shot D=5 P=0
        go(5, 0, 0);
        cyc("os_e0", 5, 1, 0, 1);
        start = 0;
        for (int n = 1; n <= 4; n++) cyc($sformatf("os_e%0d", n), 5 - n, 1, 0, 1);
        cyc("os_e5", 0, 0, 1, 0);
        for (int n = 0; n < 50; n++) cyc("os_quiet", 0, 0, 0, 0);

        // Periodic D=3 P=2: ticks every 3rd clock, roll every 9
        go(3, 2, 1);
        cyc("per_e0", 3, 1, 0, 0);
        start = 0;
        for (int n = 1; n <= 27; n++) begin
            int m;
            int ec;
            m  = n % 9;
            ec = (m < 3) ? 3 : (m < 6) ? 2 : 1;
            cyc($sformatf("per_e%0d", n), ec, 1, (m == 0) ? 1 : 0, (n % 3 == 2) ? 1 : 0);
        end
        stop = 1;
        cyc("per_stop", 3, 0, 0, 0);
        stop = 0;

        // Stop at count 4, then fresh D=2 run
        go(10, 0, 0);
        cyc("stp_e0", 10, 1, 0, 1);
        start = 0;
        for (int n = 1; n <= 6; n++) cyc($sformatf("stp_e%0d", n), 10 - n, 1, 0, 1);
        stop = 1;
        cyc("stp_hit", 4, 0, 0, 0);
        stop = 0;
        for (int n = 0; n < 50; n++) cyc("stp_quiet", 4, 0, 0, 0);
        go(2, 0, 0);
        cyc("d2_e0", 2, 1, 0, 1);
        start = 0;
        cyc("d2_e1", 1, 1, 0, 1);
        cyc("d2_e2", 0, 0, 1, 0);

        // Restart coinciding with expiry suppresses the roll
        go(3, 0, 0);
        cyc("rs_e0", 3, 1, 0, 1);
        start = 0;
        cyc("rs_e1", 2, 1, 0, 1);
        cyc("rs_e2", 1, 1, 0, 1);
        go(7, 0, 0);
        cyc("rs_e3", 7, 1, 0, 1);
        start = 0; stop = 1;
        cyc("rs_stop", 7, 0, 0, 0);
        stop = 0;

        // Zero duration rolls without running
        go(0, 0, 1);
        cyc("z_e0", 0, 0, 1, 0);
        start = 0;
        cyc("z_e1", 0, 0, 0, 0);

        // Start and stop together in IDLE: stop wins, nothing starts
        go(6, 0, 0); stop = 1;
        cyc("ss", 0, 0, 0, 0);
        start = 0; stop = 0;
        cyc("ss_after", 0, 0, 0, 0);

`ifdef TIMER_HOLD_EN
        // Hold D=4 P=1 at count 2 for 10 clocks: roll moves from edge 8 to 18
        go(4, 1, 0);
        cyc("h_e0", 4, 1, 0, 0);
        start = 0;
        cyc("h_e1", 4, 1, 0, 1);
        cyc("h_e2", 3, 1, 0, 0);
        cyc("h_e3", 3, 1, 0, 1);
        cyc("h_e4", 2, 1, 0, 0);
        hold = 1;
        for (int n = 5; n <= 14; n++) cyc($sformatf("h_e%0d", n), 2, 1, 0, 0);
        hold = 0;
        cyc("h_e15", 2, 1, 0, 1);
        cyc("h_e16", 1, 1, 0, 0);
        cyc("h_e17", 1, 1, 0, 1);
        cyc("h_e18", 0, 0, 1, 0);
`endif

        // Asynchronous reset between edges mid-run
        go(20, 3, 0);
        cyc("ar_e0", 20, 1, 0, 0);
        start = 0;
        for (int n = 1; n <= 5; n++) cyc("ar_run", (n < 4) ? 20 : 19, 1, 0, (n % 4 == 3) ? 1 : 0);
        #3;
        reset = 1'b1;
        #1;
        cmp("ar_count", int'(count), 0);
        cmp("ar_busy", int'(busy), 0);
        cmp("ar_roll", int'(roll), 0);
        cmp("ar_tick", int'(tick), 0);
        @(posedge clk); #1;
        cmp("ar_held_count", int'(count), 0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) cyc("ar_after", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
